// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared types and constants for the elastic MEM/WB register
package mem_wb_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } mem_wb_state_t;

    // Field order is MSB first; reserved bits pad the struct out to 128 bits.
    typedef struct packed {
        logic [16:0] reserved;
        logic [31:0] mem_data;
        logic [31:0] alu_o;
        logic [4:0]  rd;
        logic        mem2reg;
        logic        regs_write;
        logic [1:0]  matrix_index;
        logic        mem2matrix;
        logic        matrix_write;
        logic        matrix_write_mopa;
        logic [1:0]  mem_matrix2reg;
        logic        mem_reg2matrix;
        logic [31:0] inst;
    } mem_wb_pay_t;

    localparam int MEM_WB_PAY_W = $bits(mem_wb_pay_t);

endpackage

// File: rtl/mem_wb_lane_hold.sv
// rtl/mem_wb_lane_hold.sv - one matrix-result lane register that only updates when its write enable is set
module mem_wb_lane_hold #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            we,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load && we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_elastic.sv
// rtl/mem_wb_elastic.sv - elastic MEM->WB register with two-entry skid buffer, lane write mask, flush and stall counter
module mem_wb_elastic
    import mem_wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int LANES = 4,
    parameter int PAY_W = MEM_WB_PAY_W,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PAY_W-1:0]      in_pay,
    input  logic [LANES*XLEN-1:0] in_lane,
    input  logic [LANES-1:0]      in_lane_we,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PAY_W-1:0]      out_pay,
    output logic [LANES*XLEN-1:0] out_lane,
    output logic [LANES-1:0]      out_lane_we,
    output logic [CNT_W-1:0]      stall_cnt
);

    mem_wb_state_t state, next_state;

    logic                  push;
    logic                  pop;
    logic                  main_load;
    logic                  main_from_skid;
    logic                  skid_load;

    logic [PAY_W-1:0]      skid_pay;
    logic [LANES*XLEN-1:0] skid_lane;
    logic [LANES-1:0]      skid_we;

    logic [PAY_W-1:0]      main_pay_d;
    logic [LANES-1:0]      main_we_d;
    logic [LANES*XLEN-1:0] main_lane_d;

    assign push      = in_valid & in_ready;
    assign out_valid = (state != EMPTY);
    assign pop       = out_valid & out_ready;

    always_comb begin
        next_state     = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        next_state = ONE;
                        main_load  = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (push) begin
                        next_state = TWO;
                        skid_load  = 1'b1;
                    end else if (pop) begin
                        next_state = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        next_state     = ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    assign main_pay_d  = main_from_skid ? skid_pay  : in_pay;
    assign main_we_d   = main_from_skid ? skid_we   : in_lane_we;
    assign main_lane_d = main_from_skid ? skid_lane : in_lane;

    // in_ready is registered so WB backpressure never reaches MEM combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != TWO);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_pay     <= '0;
            out_lane_we <= '0;
        end else if (main_load) begin
            out_pay     <= main_pay_d;
            out_lane_we <= main_we_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_pay  <= '0;
            skid_lane <= '0;
            skid_we   <= '0;
        end else if (skid_load) begin
            skid_pay  <= in_pay;
            skid_lane <= in_lane;
            skid_we   <= in_lane_we;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mem_wb_lane_hold #(
            .XLEN(XLEN)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .load (main_load),
            .we   (main_we_d[i]),
            .d    (main_lane_d[i*XLEN +: XLEN]),
            .q    (out_lane[i*XLEN +: XLEN])
        );
    end

    // Flush does not clear the counter; only reset does.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_wb_elastic.sv
// tb/tb_mem_wb_elastic.sv - scoreboard bench for mem_wb_elastic with directed and random stimulus
module tb_mem_wb_elastic;

    localparam int XLEN  = 32;
    localparam int LANES = 4;
    localparam int PAY_W = 128;
    localparam int CNT_W = 4;
    localparam int LW    = LANES * XLEN;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [PAY_W-1:0] in_pay;
    logic [LW-1:0]    in_lane;
    logic [LANES-1:0] in_lane_we;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [PAY_W-1:0] out_pay;
    logic [LW-1:0]    out_lane;
    logic [LANES-1:0] out_lane_we;
    logic [CNT_W-1:0] stall_cnt;

    mem_wb_elastic #(
        .XLEN(XLEN), .LANES(LANES), .PAY_W(PAY_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pay(in_pay),
        .in_lane(in_lane), .in_lane_we(in_lane_we), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pay(out_pay),
        .out_lane(out_lane), .out_lane_we(out_lane_we), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PAY_W-1:0] pay;
        logic [LW-1:0]    lane;
        logic [LANES-1:0] we;
    } beat_t;

    int checks = 0;
    int errors = 0;

    // Reference model: ordered queue of accepted beats plus the visible output register contents.
    beat_t            q[$];
    logic [LW-1:0]    m_lane;
    logic [PAY_W-1:0] m_pay;
    logic [LANES-1:0] m_we;
    int               m_stall;
    bit               head_seen;

    task automatic chk(input string name, input logic [PAY_W-1:0] act, input logic [PAY_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PAY_W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                q.delete();
                m_lane = '0; m_pay = '0; m_we = '0; m_stall = 0; head_seen = 0;
            end else begin
                bit    push_e, pop_e;
                beat_t nb;
                if (q.size() > 0 && !head_seen) begin
                    for (int i = 0; i < LANES; i++)
                        if (q[0].we[i]) m_lane[i*XLEN +: XLEN] = q[0].lane[i*XLEN +: XLEN];
                    m_pay = q[0].pay;
                    m_we  = q[0].we;
                    head_seen = 1;
                end
                chk("out_valid", out_valid, q.size() > 0);
                chk("in_ready", in_ready, q.size() < 2);
                chk("out_pay", out_pay, m_pay);
                chk("out_lane", out_lane, m_lane);
                chk("out_lane_we", out_lane_we, m_we);
                chk("stall_cnt", stall_cnt, m_stall);
                push_e = in_valid && (q.size() < 2);
                pop_e  = (q.size() > 0) && out_ready;
                if (q.size() > 0 && !out_ready && m_stall < (2**CNT_W - 1)) m_stall++;
                if (flush) begin
                    q.delete();
                    head_seen = 0;
                end else begin
                    if (pop_e) begin
                        void'(q.pop_front());
                        head_seen = 0;
                    end
                    if (push_e) begin
                        nb.pay = in_pay; nb.lane = in_lane; nb.we = in_lane_we;
                        q.push_back(nb);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 0; flush = 0; out_ready = 0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        rst = 0; in_valid = 0; in_pay = '0; in_lane = '0; in_lane_we = '0;
        flush = 0; out_ready = 0;
        step(); step();
        rst = 1'b1;

        // single beat after reset
        in_valid = 1; in_pay = 128'hA5; in_lane = 128'h1111_1111; in_lane_we = 4'hF; out_ready = 1;
        step();
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_pay", out_pay, 128'hA5);
        in_valid = 0;
        step();
        chk("t1_drain", out_valid, 1'b0);

        // streaming
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_pay = 128'(100 + i); in_lane = rnd128(); in_lane_we = 4'($urandom);
            step();
            chk("t2_in_ready", in_ready, 1'b1);
        end
        in_valid = 0;
        step(); step();
        chk("t2_stall", stall_cnt, 0);

        // skid fill and drain
        do_reset();
        out_ready = 1; in_valid = 1; in_pay = 128'd1; in_lane = rnd128(); in_lane_we = 4'hF;
        step();
        in_pay = 128'd2; in_lane = rnd128(); out_ready = 0;
        step();
        chk("t3_in_ready_low", in_ready, 1'b0);
        in_pay = 128'd3; in_lane = rnd128();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_in_ready_low", in_ready, 1'b0);
        end
        out_ready = 1;
        step(); step();
        in_valid = 0;
        step(); step();
        chk("t3_stall", stall_cnt, 4);
        chk("t3_empty", out_valid, 1'b0);

        // lane mask
        out_ready = 1; in_valid = 1; in_pay = 128'hA; in_lane = {4{32'hAAAA_AAAA}}; in_lane_we = 4'hF;
        step();
        in_pay = 128'hB; in_lane = {4{32'hBBBB_BBBB}}; in_lane_we = 4'b0101;
        step();
        chk("t4_lane", out_lane, {32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hAAAA_AAAA, 32'hBBBB_BBBB});
        in_valid = 0;
        step();

        // flush in TWO with input offered, then flush in ONE with a push
        out_ready = 0; in_valid = 1; in_pay = 128'h51; in_lane = rnd128(); in_lane_we = 4'hF;
        step();
        in_pay = 128'h52; in_lane = rnd128();
        step();
        in_pay = 128'h53; flush = 1;
        step();
        flush = 0; in_valid = 0;
        chk("t5_valid", out_valid, 1'b0);
        chk("t5_ready", in_ready, 1'b1);
        in_valid = 1; in_pay = 128'h54;
        step();
        in_pay = 128'h55; flush = 1;
        step();
        flush = 0; in_valid = 0;
        chk("t5_valid_one", out_valid, 1'b0);
        out_ready = 1;
        step(); step(); step();
        chk("t5_idle", out_valid, 1'b0);

        // asynchronous reset while TWO
        out_ready = 0; in_valid = 1; in_pay = 128'h61; in_lane = rnd128(); in_lane_we = 4'hF;
        step();
        in_pay = 128'h62;
        step();
        in_valid = 0;
        #1 rst = 0;
        #1;
        chk("t6_valid", out_valid, 1'b0);
        chk("t6_pay", out_pay, '0);
        chk("t6_lane", out_lane, '0);
        chk("t6_we", out_lane_we, '0);
        chk("t6_ready", in_ready, 1'b1);
        chk("t6_stall", stall_cnt, 0);
        step();
        rst = 1;

        // stall counter saturation
        in_valid = 1; in_pay = 128'h71; out_ready = 0;
        step();
        in_valid = 0;
        for (int i = 0; i < 20; i++) step();
        chk("t7_sat", stall_cnt, 15);
        out_ready = 1;
        step(); step();

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_pay     = rnd128();
            in_lane    = rnd128();
            in_lane_we = 4'($urandom);
            flush      = ($urandom_range(0, 31) == 0);
            out_ready  = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            if (i == 1500) begin
                rst = 0;
                step();
                rst = 1;
            end
            step();
        end
        in_valid = 0; flush = 0; out_ready = 1;
        for (int i = 0; i < 4; i++) step();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
